// File: rtl/opb_register_bank_simulink2ppc.sv
// rtl/opb_register_bank_simulink2ppc.sv - OPB slave exposing C_NUM_CH user data words with coherent snapshot capture
//
// Ports:
//   OPB_Clk, OPB_Rst_n      bus/user clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW    OPB request (big-endian bit numbering, bit 0 = MSB)
//   OPB_select, OPB_seqAddr transfer request; seqAddr is not used
//   Sl_DBus, Sl_xferAck     registered read data and acknowledge
//   Sl_errAck/retry/toutSup tied low
//   user_data_in/user_valid packed channel data and its qualifier
//   snap_armed              registered copy of the armed flag
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0103C100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0103C1FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_DATA_WIDTH = 32,
    parameter int          C_SNAP_MODE  = 1
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]          OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]        OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]          OPB_DBus,
    input  logic                             OPB_RNW,
    input  logic                             OPB_select,
    input  logic                             OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]          Sl_DBus,
    output logic                             Sl_errAck,
    output logic                             Sl_retry,
    output logic                             Sl_toutSup,
    output logic                             Sl_xferAck,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
    input  logic                             user_valid,
    output logic                             snap_armed
);

    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] diff;
    logic [29:0] offset;
    logic        hit;
    logic        accept;
    logic        ctrl_wr;
    logic        load;
    logic [31:0] rd_val;

    logic                    ack_q, ack_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    armed_q, armed_d;
    logic                    captured_q, captured_d;
    logic [15:0]             count_q, count_d;
    logic [C_DATA_WIDTH-1:0] ch_q [C_NUM_CH];

    // Vector assignment keeps the numeric value, so OPB bit 31 lands on value bit 0.
    assign addr   = OPB_ABus;
    assign wdata  = OPB_DBus;
    assign diff   = addr - C_BASEADDR;
    assign offset = diff[31:2];
    assign hit    = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    // The cycle that raises the ack is the single point where a transfer takes effect.
    assign accept  = hit && !ack_q;
    assign ctrl_wr = accept && !OPB_RNW && (offset == 30'd0) && OPB_BE[0];
    assign load    = (C_SNAP_MODE != 0) ? (armed_q && user_valid) : user_valid;

    always_comb begin
        rd_val = '0;
        if (offset == 30'd0) begin
            rd_val = {armed_q, captured_q, 14'd0, count_q};
        end else begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (offset == 30'(i + 1)) begin
                    rd_val = 32'(ch_q[i]);
                end
            end
        end
    end

    always_comb begin
        ack_d      = accept;
        rdata_d    = (accept && OPB_RNW) ? rd_val : 32'd0;
        armed_d    = armed_q;
        captured_d = captured_q;
        count_d    = count_q;
        // Capture consumes the armed value from before this cycle's write.
        if (load) begin
            armed_d    = 1'b0;
            captured_d = 1'b1;
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
        end
        if (ctrl_wr && wdata[31] && (C_SNAP_MODE != 0)) begin
            armed_d = 1'b1;
        end
        // Clear overrides a coincident capture's status update; channel data still loads.
        if (ctrl_wr && wdata[30]) begin
            captured_d = 1'b0;
            count_d    = 16'd0;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            armed_q    <= 1'b0;
            captured_q <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < C_NUM_CH; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            armed_q    <= armed_d;
            captured_q <= captured_d;
            count_q    <= count_d;
            if (load) begin
                for (int i = 0; i < C_NUM_CH; i++) begin
                    ch_q[i] <= user_data_in[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                end
            end
        end
    end

    assign Sl_DBus    = rdata_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign snap_armed = armed_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, OPB_seqAddr, OPB_BE[1:C_OPB_DWIDTH/8-1], wdata[29:0], diff[1:0]};

endmodule
